// File: rtl/cmp_seq.sv
// cmp_seq: multi-cycle magnitude comparator, DIGIT bits per clock, MSB slice first.
// Signed operands are biased by flipping the sign bit at latch time, so the same
// unsigned slice compare serves both modes.
// Optional feature macro: CMP_EARLY_EXIT_EN (finish at the first differing slice);
// when undefined, every compare scans all NSLICE slices (constant time).
module cmp_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int unsigned NSLICE = WIDTH / DIGIT;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]    r_cnt;
  logic             r_found;
  logic             r_rec_gt;
  logic             r_rec_lt;
  logic             r_done;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;

  logic [DIGIT-1:0] w_top_a;
  logic [DIGIT-1:0] w_top_b;
  logic             w_sl_gt;
  logic             w_sl_lt;
  logic             w_last;
  logic             w_decide;
  logic             w_res_eq;
  logic             w_res_gt;
  logic             w_res_lt;
  logic [WIDTH-1:0] w_bias;

  assign w_top_a = r_sa[WIDTH-1 -: DIGIT];
  assign w_top_b = r_sb[WIDTH-1 -: DIGIT];
  assign w_sl_gt = (w_top_a > w_top_b);
  assign w_sl_lt = (w_top_a < w_top_b);
  assign w_last  = (r_cnt == LAST);
  assign w_bias  = signed_mode ? SIGN_BIT : '0;

  // Decision point and the result that will be registered when it is reached
  always_comb begin
    w_decide = 1'b0;
    w_res_eq = 1'b0;
    w_res_gt = 1'b0;
    w_res_lt = 1'b0;
`ifdef CMP_EARLY_EXIT_EN
    w_decide = w_sl_gt | w_sl_lt | w_last;
    w_res_gt = w_sl_gt;
    w_res_lt = w_sl_lt;
    w_res_eq = ~(w_sl_gt | w_sl_lt);
`else
    // The first recorded difference wins; later slices only matter if none was seen
    w_decide = w_last;
    if (r_found) begin
      w_res_gt = r_rec_gt;
      w_res_lt = r_rec_lt;
    end else begin
      w_res_gt = w_sl_gt;
      w_res_lt = w_sl_lt;
      w_res_eq = ~(w_sl_gt | w_sl_lt);
    end
`endif
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_decide) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand shift registers, slice counter, difference record and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_cnt    <= '0;
      r_found  <= 1'b0;
      r_rec_gt <= 1'b0;
      r_rec_lt <= 1'b0;
      r_done   <= 1'b0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
      r_lt     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sa     <= a ^ w_bias;
            r_sb     <= b ^ w_bias;
            r_cnt    <= '0;
            r_found  <= 1'b0;
            r_rec_gt <= 1'b0;
            r_rec_lt <= 1'b0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
          end
        end
        RUN: begin
          if (w_decide) begin
            r_done <= 1'b1;
            r_eq   <= w_res_eq;
            r_gt   <= w_res_gt;
            r_lt   <= w_res_lt;
          end else begin
            r_sa  <= r_sa << DIGIT;
            r_sb  <= r_sb << DIGIT;
            r_cnt <= r_cnt + CW'(1);
            if (!r_found && (w_sl_gt || w_sl_lt)) begin
              r_found  <= 1'b1;
              r_rec_gt <= w_sl_gt;
              r_rec_lt <= w_sl_lt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign eq   = r_eq;
  assign gt   = r_gt;
  assign lt   = r_lt;

endmodule

// File: tb/tb_cmp_seq.sv
// tb_cmp_seq: directed test of cmp_seq (WIDTH=32, DIGIT=8) with immediate assertions.
module tb_cmp_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, eq, gt, lt;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;

`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  cmp_seq #(.WIDTH(32), .DIGIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input int k);
    return EARLY ? k + 1 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    do begin
      tick();
      l++;
    end while (done !== 1'b1 && l < 20);
  endtask

  // One full compare: start for one cycle, then check latency and result {eq,gt,lt}
  task automatic run_cmp(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic sgn, input logic [2:0] exp_res, input int exp_l);
    int l;
    a = va; b = vb; signed_mode = sgn; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_accept"}, {27'd0, busy, done, eq, gt, lt}, 32'b10000);
    wait_done(l);
    check({tag, "_lat"}, l, exp_l);
    check({tag, "_res"}, {29'd0, eq, gt, lt}, {29'd0, exp_res});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state before any clock edge
    #2;
    check("reset_init", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Unsigned equal, then results held with done low
    run_cmp("ueq", 32'h12345678, 32'h12345678, 1'b0, 3'b100, 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ueq_hold", {27'd0, busy, done, eq, gt, lt}, 32'b00100);
    end

    // Unsigned early difference
    run_cmp("uearly", 32'hFF000000, 32'h01000000, 1'b0, 3'b010, exp_lat(0));

    // Asynchronous reset between edges clears outputs at once
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();

    // Signed mode
    run_cmp("searly", 32'hFF000000, 32'h01000000, 1'b1, 3'b001, exp_lat(0));
    run_cmp("smin",   32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b001, exp_lat(0));
    run_cmp("umin",   32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b010, exp_lat(0));
    run_cmp("zero",   32'h00000000, 32'h00000000, 1'b0, 3'b100, 4);

    // Last-slice difference with start held high; operand changes during RUN ignored
    a = 32'h00000100; b = 32'h00000101; signed_mode = 1'b0; start = 1'b1;
    tick();
    check("held_accept", {27'd0, busy, done, eq, gt, lt}, 32'b10000);
    a = 32'h00000202; b = 32'h00000202; signed_mode = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("held_run", {27'd0, busy, done, eq, gt, lt}, 32'b10000);
    end
    tick();
    check("held_done", {27'd0, busy, done, eq, gt, lt}, 32'b01001);
    tick();
    check("b2b_accept", {27'd0, busy, done, eq, gt, lt}, 32'b10000);
    start = 1'b0;
    wait_done(lat);
    check("b2b_lat", lat, 4);
    check("b2b_res", {29'd0, eq, gt, lt}, 32'b100);

    // Reset mid-operation aborts without a done pulse
    tick();
    a = 32'h00000001; b = 32'h00000002; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_now", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    tick();
    tick();
    check("abort_held", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_nodone", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    end
    run_cmp("after_abort", 32'h00000001, 32'h00000002, 1'b0, 3'b001, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_seq.md
Name: cmp_seq

Overview:
- Parametrised, multi-cycle magnitude comparator.
- Successor to the 8-bit combinational eq/gt/lt comparator.
- Compares two WIDTH-bit operands DIGIT bits per clock, most-significant slice first, in unsigned or signed mode.
- Uses a start/busy/done handshake and registered, one-hot eq/gt/lt results. Used wherever wide operands must be compared without a full-width combinational compare path.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 8, bits compared per cycle; NSLICE = WIDTH/DIGIT, must be at least 1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a compare; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when eq/gt/lt become valid.
- eq  output  1  A == B.
- gt  output  1  A > B.
- lt  output  1  A < B.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, on rst_n.
  - rst_n low forces, immediately and regardless of clk: state IDLE; busy, done, eq, gt, lt = 0; internal shift registers and slice counter = 0.
- States: IDLE, RUN.
- IDLE -> RUN, when start is high at a rising edge:
  - Latch a and b into shift registers sa and sb.
  - If signed_mode = 1, invert bit WIDTH-1 of both sa and sb at latch. This biases signed operands into the unsigned ordering, so one unsigned slice compare serves both modes.
  - Slice counter = 0; busy = 1; eq/gt/lt cleared to 000.
- RUN, each cycle: compare the top slices sa[WIDTH-1:WIDTH-DIGIT] and sb[WIDTH-1:WIDTH-DIGIT] as unsigned.
  - Slices differ: record gt or lt. With CMP_EARLY_EXIT_EN this is the decision edge.
  - Slices equal: shift sa and sb left by DIGIT and increment the counter.
  - Counter = NSLICE-1 with no difference recorded: result is eq.
- Decision edge:
  - Exactly one of eq/gt/lt is set; done = 1 for one cycle; busy = 0; state returns to IDLE.
- Latency:
  - A start accepted at edge 0 gives done high in the cycle following edge k+1, where k is the slice index that decides the result (k = NSLICE-1 for eq).
  - Maximum latency is NSLICE cycles.
- Result hold:
  - eq/gt/lt stay constant after done until the next start is accepted.
  - A start sampled in the same cycle that done is high is accepted; results clear at that edge.
- start while busy = 1 is ignored. Operands and signed_mode changing during RUN have no effect.
- Reset mid-RUN aborts the compare: no done pulse, outputs 000.
- Edge cases:
  - DIGIT = WIDTH gives a single-cycle compare.
  - a = b = 0 gives eq.
  - Signed 0x80..0 vs 0x7F..F gives lt.

Optional Feature:
- Macro: CMP_EARLY_EXIT_EN.
- Defined: RUN ends at the first differing slice, giving latency k+1.
- Undefined: constant-time mode.
  - The first difference is still recorded, but scanning continues through all NSLICE slices.
  - Later slices never overwrite the recorded result.
  - done always occurs NSLICE cycles after start.

Test Plan (WIDTH=32, DIGIT=8):
- Reset: pulse rst_n low between clock edges -> busy, done, eq, gt, lt = 0 immediately, without waiting for clk.
- Unsigned equal: a=0x12345678, b=0x12345678 -> done 4 cycles after start; eq=1, gt=0, lt=0; results held until next start.
- Unsigned early difference: a=0xFF000000, b=0x01000000 -> gt=1; done after 1 cycle with CMP_EARLY_EXIT_EN, after 4 cycles without.
- Signed mode: same operands, signed_mode=1 (-16777216 vs 16777216) -> lt=1. Also a=0x80000000, b=0x7FFFFFFF signed -> lt=1; unsigned -> gt=1.
- Last-slice difference with start held: a=0x00000100, b=0x00000101, start held high throughout -> lt=1 at 4 cycles; extra starts during busy ignored. Back-to-back start in the done cycle is accepted and clears eq/gt/lt.
- Reset mid-operation: a=0x00000001, b=0x00000002, rst_n low 2 cycles after start -> busy=0, no done pulse, eq/gt/lt=000. Next compare after reset completes normally.
